// File: rtl/clk_mon_pkg.sv
// ---------------------------------------------------------------------------
// clk_mon_pkg
// Shared types and defaults for the derived-clock ratio monitor.
//   chan_state_e : per-channel FSM state (IDLE, ARM, MEASURE, LOCKED)
//   DEF_*        : default counter width, lock depth and stuck timeout
//   abs_diff     : unsigned absolute difference used for period comparison
// ---------------------------------------------------------------------------
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } chan_state_e;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_TIMEOUT  = 200;

    // Operands are zero-extended by the caller, so the subtraction never wraps.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_mon_chan.sv
// ---------------------------------------------------------------------------
// clk_mon_chan
// One monitored clock channel: 2-flop synchronizer plus history flop, rising
// edge detect, saturating period counter, IDLE/ARM/MEASURE/LOCKED FSM and the
// sticky period / stuck error flags.
//   clk_i, rst_i      : monitor clock, async active-high reset
//   enable_i          : measurement enable (0 forces IDLE)
//   clr_err_i         : clears both sticky flags (a same-cycle set wins)
//   mon_clk_i         : derived clock, sampled as asynchronous data
//   exp_period_i      : expected period in clk_i cycles
//   period_o          : last measured period
//   period_valid_o    : one-cycle pulse when period_o updates
//   lock_o            : LOCK_CNT consecutive matching periods seen
//   err_period_o      : sticky, a period fell outside tolerance
//   err_stuck_o       : sticky, no rising edge within TIMEOUT cycles
// ---------------------------------------------------------------------------
module clk_mon_chan
    import clk_mon_pkg::*;
#(
    parameter int          CNT_W    = DEF_CNT_W,
    parameter int unsigned TOL      = 0,
    parameter int          LOCK_CNT = DEF_LOCK_CNT,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clr_err_i,
    input  logic             mon_clk_i,
    input  logic [CNT_W-1:0] exp_period_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             lock_o,
    output logic             err_period_o,
    output logic             err_stuck_o
);

    localparam int               MC_W        = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  MC_ONE      = MC_W'(1);
    localparam logic [MC_W-1:0]  MC_FULL     = MC_W'(LOCK_CNT);

    chan_state_e      state_q;
    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc_d, period_q;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic             valid_q, lock_q;
    logic             err_period_q, err_period_d;
    logic             err_stuck_q, err_stuck_d;
    logic             edge_det, is_match, measuring, take_meas, stuck_hit;

    assign edge_det    = sync2_q & ~hist_q;
    assign cnt_inc_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    assign match_cnt_d = (match_cnt_q == MC_FULL) ? match_cnt_q : match_cnt_q + MC_ONE;
    assign is_match    = abs_diff(32'(cnt_q), 32'(exp_period_i)) <= TOL;
    assign measuring   = enable_i && (state_q == ST_MEASURE || state_q == ST_LOCKED);
    assign take_meas   = measuring && edge_det;
    // An edge arriving exactly at TIMEOUT is a measurement, not a stuck fault.
    assign stuck_hit   = enable_i && (state_q != ST_IDLE) && !edge_det && (cnt_q == CNT_TIMEOUT);

    // Sticky flags: a new set in the same cycle as clr_err survives the clear.
    assign err_period_d = (take_meas && !is_match) || (err_period_q && !clr_err_i);
    assign err_stuck_d  = stuck_hit || (err_stuck_q && !clr_err_i);

    // NOTE: every register is written with <= so all flops update from the same
    // pre-edge values; a blocking write here would let later lines see new state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            match_cnt_q  <= '0;
            valid_q      <= 1'b0;
            lock_q       <= 1'b0;
            err_period_q <= 1'b0;
            err_stuck_q  <= 1'b0;
        end else begin
            // Synchronizer keeps running even while disabled.
            sync1_q      <= mon_clk_i;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            err_period_q <= err_period_d;
            err_stuck_q  <= err_stuck_d;
            valid_q      <= take_meas;
            if (take_meas) begin
                period_q <= cnt_q;
            end

            if (!enable_i) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                match_cnt_q <= '0;
                lock_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                        cnt_q   <= '0;
                    end
                    ST_ARM: begin
                        if (edge_det) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= ST_MEASURE;
                        end else if (stuck_hit) begin
                            cnt_q       <= '0;
                            match_cnt_q <= '0;
                            lock_q      <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        if (edge_det) begin
                            cnt_q <= CNT_ONE;
                            if (is_match) begin
                                match_cnt_q <= match_cnt_d;
                                if (match_cnt_d == MC_FULL) begin
                                    state_q <= ST_LOCKED;
                                    lock_q  <= 1'b1;
                                end
                            end else begin
                                match_cnt_q <= '0;
                                lock_q      <= 1'b0;
                                state_q     <= ST_MEASURE;
                            end
                        end else if (stuck_hit) begin
                            // Dead clock: re-arm and count again so the fault repeats.
                            state_q     <= ST_ARM;
                            cnt_q       <= '0;
                            match_cnt_q <= '0;
                            lock_q      <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign lock_o         = lock_q;
    assign err_period_o   = err_period_q;
    assign err_stuck_o    = err_stuck_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// clk_ratio_monitor
// Observes N_CH derived clocks in the clk_in domain, measures each rising-edge
// period and checks it against a programmed expectation.
//   clk_in, rst   : monitor clock, async active-high reset
//   enable        : global measurement enable
//   mon_clk       : derived-clock nets, one bit per channel
//   exp_period    : expected periods, channel i at [i*CNT_W +: CNT_W]
//   clr_err       : pulse, clears all sticky error flags
//   period_out    : last measured periods, same packing as exp_period
//   period_valid  : per-channel update pulse
//   lock          : per-channel lock
//   err_period    : per-channel sticky period mismatch
//   err_stuck     : per-channel sticky stuck clock
// ---------------------------------------------------------------------------
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int          N_CH     = 4,
    parameter int          CNT_W    = DEF_CNT_W,
    parameter int unsigned TOL      = 0,
    parameter int          LOCK_CNT = DEF_LOCK_CNT,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N_CH-1:0]       mon_clk,
    input  logic [N_CH*CNT_W-1:0] exp_period,
    input  logic                  clr_err,
    output logic [N_CH*CNT_W-1:0] period_out,
    output logic [N_CH-1:0]       period_valid,
    output logic [N_CH-1:0]       lock,
    output logic [N_CH-1:0]       err_period,
    output logic [N_CH-1:0]       err_stuck
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        clk_mon_chan #(
            .CNT_W    (CNT_W),
            .TOL      (TOL),
            .LOCK_CNT (LOCK_CNT),
            .TIMEOUT  (TIMEOUT)
        ) u_chan (
            .clk_i          (clk_in),
            .rst_i          (rst),
            .enable_i       (enable),
            .clr_err_i      (clr_err),
            .mon_clk_i      (mon_clk[g]),
            .exp_period_i   (exp_period[g*CNT_W +: CNT_W]),
            .period_o       (period_out[g*CNT_W +: CNT_W]),
            .period_valid_o (period_valid[g]),
            .lock_o         (lock[g]),
            .err_period_o   (err_period[g]),
            .err_stuck_o    (err_stuck[g])
        );
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_ratio_monitor
// Directed bench for clk_ratio_monitor. A second instance with TOL=2 sees the
// same stimulus so the tolerance behaviour can be compared side by side.
// ---------------------------------------------------------------------------
module tb_clk_ratio_monitor;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    logic                  clk_in;
    logic                  rst;
    logic                  enable;
    logic                  clr_err;
    logic [N_CH-1:0]       mon_clk;
    logic [N_CH*CNT_W-1:0] exp_period;

    logic [N_CH*CNT_W-1:0] period_out, tol_period_out;
    logic [N_CH-1:0]       period_valid, tol_period_valid;
    logic [N_CH-1:0]       lock, tol_lock;
    logic [N_CH-1:0]       err_period, tol_err_period;
    logic [N_CH-1:0]       err_stuck, tol_err_stuck;

    clk_ratio_monitor dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .mon_clk      (mon_clk),
        .exp_period   (exp_period),
        .clr_err      (clr_err),
        .period_out   (period_out),
        .period_valid (period_valid),
        .lock         (lock),
        .err_period   (err_period),
        .err_stuck    (err_stuck)
    );

    clk_ratio_monitor #(.TOL(2)) dut_tol (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .mon_clk      (mon_clk),
        .exp_period   (exp_period),
        .clr_err      (clr_err),
        .period_out   (tol_period_out),
        .period_valid (tol_period_valid),
        .lock         (tol_lock),
        .err_period   (tol_err_period),
        .err_stuck    (tol_err_stuck)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Derived-clock pattern generator: per channel high/low lengths in clk_in
    // cycles, a run flag (0 holds the net low) and a request to drop one high phase.
    int hi_len   [N_CH];
    int lo_len   [N_CH];
    bit run      [N_CH];
    int drop_req [N_CH];
    int drop_done[N_CH];
    int ph       [N_CH];

    initial begin
        mon_clk = '0;
        for (int c = 0; c < N_CH; c++) begin
            ph[c]        = 0;
            drop_done[c] = 0;
        end
        forever begin
            @(posedge clk_in);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (!run[c]) begin
                    mon_clk[c] = 1'b0;
                    ph[c]      = 0;
                end else begin
                    ph[c]++;
                    if (mon_clk[c]) begin
                        if (ph[c] >= hi_len[c]) begin
                            mon_clk[c] = 1'b0;
                            ph[c]      = 0;
                        end
                    end else if (ph[c] >= lo_len[c]) begin
                        if (drop_done[c] != drop_req[c]) begin
                            drop_done[c]++;
                            ph[c] = -hi_len[c];
                        end else begin
                            mon_clk[c] = 1'b1;
                            ph[c]      = 0;
                        end
                    end
                end
            end
        end
    end

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [CNT_W-1:0] per(input int ch);
        return period_out[ch*CNT_W +: CNT_W];
    endfunction

    task automatic set_chan(input int ch, input int hi, input int lo, input int expp);
        hi_len[ch] = hi;
        lo_len[ch] = lo;
        exp_period[ch*CNT_W +: CNT_W] = CNT_W'(expp);
    endtask

    // Wait (at negedges) until n period_valid pulses of channel ch are seen.
    task automatic wait_valid(input int ch, input int n);
        int seen   = 0;
        int budget = n * 300 + 50;
        while (seen < n && budget > 0) begin
            @(negedge clk_in);
            budget--;
            if (period_valid[ch]) seen++;
        end
        if (seen < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_valid ch%0d: saw %0d pulses, required %0d", ch, seen, n);
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk_in);
        clr_err = 1'b0;
    endtask

    typedef struct {
        int hi;
        int lo;
        int expp;
        int per;
        bit lk;
        bit ep;
        bit es;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bit found;

        vecs[0] = '{hi: 1,   lo: 1,   expp: 2,   per: 2,   lk: 1, ep: 0, es: 0};
        vecs[1] = '{hi: 2,   lo: 2,   expp: 4,   per: 4,   lk: 1, ep: 0, es: 0};
        vecs[2] = '{hi: 3,   lo: 2,   expp: 5,   per: 5,   lk: 1, ep: 0, es: 0};
        vecs[3] = '{hi: 1,   lo: 1,   expp: 3,   per: 2,   lk: 0, ep: 1, es: 0};
        vecs[4] = '{hi: 5,   lo: 5,   expp: 10,  per: 10,  lk: 1, ep: 0, es: 0};
        vecs[5] = '{hi: 2,   lo: 1,   expp: 3,   per: 3,   lk: 1, ep: 0, es: 0};
        vecs[6] = '{hi: 100, lo: 100, expp: 200, per: 200, lk: 1, ep: 0, es: 0};

        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        clr_err    = 1'b0;
        exp_period = '0;
        for (int c = 0; c < N_CH; c++) begin
            run[c]      = 1'b0;
            hi_len[c]   = 1;
            lo_len[c]   = 1;
            drop_req[c] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk_in);
        check("reset_outputs", {period_out, period_valid, lock, err_period, err_stuck}, 0);
        check("reset_outputs_tol", {tol_period_out, tol_period_valid, tol_lock, tol_err_period, tol_err_stuck}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
        check("post_reset_outputs", {period_out, period_valid, lock, err_period, err_stuck}, 0);

        // Start all channels
        set_chan(0, 1, 1, 2);
        set_chan(1, 2, 2, 2);
        set_chan(2, 1, 1, 2);
        set_chan(3, 1, 1, 2);
        for (int c = 0; c < N_CH; c++) run[c] = 1'b1;
        enable = 1'b1;

        // Div2 lock on channel 0: lock with the 4th measurement
        for (int k = 1; k <= 4; k++) begin
            wait_valid(0, 1);
            check($sformatf("t1_period_%0d", k), per(0), 2);
            check($sformatf("t1_lock_%0d", k), lock[0], (k == 4));
        end
        check("t1_err_period", err_period[0], 0);
        check("t1_err_stuck", err_stuck[0], 0);

        // Div4 against wrong expectation, then reprogram and clear
        wait_valid(1, 1);
        check("t2_period", per(1), 4);
        check("t2_err_period", err_period[1], 1);
        check("t2_lock", lock[1], 0);
        exp_period[1*CNT_W +: CNT_W] = 8'd4;
        @(negedge clk_in);
        pulse_clr();
        check("t2_err_cleared", err_period[1], 0);
        for (int k = 1; k <= 4; k++) begin
            wait_valid(1, 1);
            check($sformatf("t2_lock_%0d", k), lock[1], (k == 4));
        end
        check("t2_period_after", per(1), 4);

        // Stuck clock on channel 2
        check("t3_lock_before", lock[2], 1);
        run[2] = 1'b0;
        n      = 0;
        found  = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk_in);
            if (period_valid[2]) n = 0;
            else n++;
            if (err_stuck[2]) found = 1'b1;
        end
        check("t3_stuck_seen", found, 1);
        check("t3_stuck_latency", n, 200);
        check("t3_lock_dropped", lock[2], 0);
        run[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_valid(2, 1);
            check($sformatf("t3_relock_%0d", k), lock[2], (k == 4));
        end
        check("t3_no_period_err", err_period[2], 0);

        // Dropped high phase on channel 3, TOL=0 vs TOL=2
        check("t4_lock_before", lock[3], 1);
        check("t4_tol_lock_before", tol_lock[3], 1);
        drop_req[3]++;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk_in);
            if (err_period[3]) found = 1'b1;
        end
        check("t4_err_seen", found, 1);
        check("t4_period", per(3), 4);
        check("t4_lock_dropped", lock[3], 0);
        check("t4_tol_period", tol_period_out[3*CNT_W +: CNT_W], 4);
        check("t4_tol_no_err", tol_err_period[3], 0);
        check("t4_tol_lock_held", tol_lock[3], 1);

        // Disable: locks drop, sticky flags and periods retained
        enable = 1'b0;
        @(negedge clk_in);
        check("dis_lock", lock, 0);
        repeat (10) @(negedge clk_in);
        check("dis_valid", period_valid, 0);
        check("dis_period1", per(1), 4);
        check("dis_err_period3", err_period[3], 1);
        check("dis_err_stuck2", err_stuck[2], 1);
        enable = 1'b1;

        // Table-driven steady-state vectors on channel 0
        for (int i = 0; i < 7; i++) begin
            set_chan(0, vecs[i].hi, vecs[i].lo, vecs[i].expp);
            wait_valid(0, 3);
            pulse_clr();
            wait_valid(0, 5);
            check($sformatf("vec%0d_period", i), per(0), vecs[i].per);
            check($sformatf("vec%0d_lock", i), lock[0], vecs[i].lk);
            check($sformatf("vec%0d_err_period", i), err_period[0], vecs[i].ep);
            check($sformatf("vec%0d_err_stuck", i), err_stuck[0], vecs[i].es);
        end

        // Period one past TIMEOUT: repeated stuck faults, never a measurement
        set_chan(0, 101, 100, 201);
        repeat (450) @(negedge clk_in);
        pulse_clr();
        repeat (450) @(negedge clk_in);
        check("t201_err_stuck", err_stuck[0], 1);
        check("t201_err_period", err_period[0], 0);
        check("t201_lock", lock[0], 0);

        // Reset mid-lock, then re-measure and set-wins-over-clear
        set_chan(0, 1, 1, 2);
        wait_valid(0, 8);
        check("t5_lock_before", lock[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_reset_outputs", {period_out, period_valid, lock, err_period, err_stuck}, 0);
        check("t5_reset_outputs_tol", {tol_period_out, tol_period_valid, tol_lock, tol_err_period, tol_err_stuck}, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("t5_after_release", {period_out, period_valid, lock, err_period, err_stuck}, 0);
        wait_valid(0, 1);
        check("t5_remeasure", per(0), 2);
        exp_period[0 +: CNT_W] = 8'd3;
        @(negedge clk_in);
        clr_err = 1'b1;
        @(negedge clk_in);
        clr_err = 1'b0;
        check("t5_valid_align", period_valid[0], 1);
        check("t5_set_wins", err_period[0], 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
- Observer for derived clocks (divided, gated and muxed) produced elsewhere in the design.
- Samples up to N_CH derived-clock nets as data in the clk_in domain and measures each rising-edge period in clk_in cycles.
- Checks each period against a programmed expectation; reports lock, period mismatch and stuck-clock faults.
- Sits beside the clock-generation logic as a self-check and debug block.

Parameters:
N_CH, 4, number of monitored clock channels
CNT_W, 8, period counter and expected-period width
TOL, 0, allowed absolute period deviation in clk_in cycles
LOCK_CNT, 4, consecutive matching periods required to assert lock
TIMEOUT, 200, cycles without a detected rising edge before stuck fault (must be < 2^CNT_W)

Ports:
clk_in  input  1  sole clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  global measurement enable
mon_clk  input  N_CH  derived-clock nets sampled as asynchronous data
exp_period  input  N_CH*CNT_W  expected period per channel; channel i at [i*CNT_W +: CNT_W]
clr_err  input  1  single-cycle pulse; clears all sticky error flags
period_out  output  N_CH*CNT_W  last measured period per channel
period_valid  output  N_CH  one-cycle pulse when period_out[i] updates
lock  output  N_CH  channel period stable and matching
err_period  output  N_CH  sticky: a measured period fell outside tolerance
err_stuck  output  N_CH  sticky: no rising edge within TIMEOUT cycles

Behaviour:
- Reset and interface: clock clk_in, reset rst, asynchronous assert, active high. All flops, including the synchronizers, clear to 0. All outputs are 0 during and after reset. The per-channel state is IDLE.
- Front end, per channel: 2-flop synchronizer s1->s2, plus history flop s3. A rising edge is detected in the cycle where s2=1 and s3=0. The pin-to-detect latency is a fixed 3 cycles, so measured periods are unaffected by it.
- Counter cnt:
  - Loads 1 on a detected edge.
  - Otherwise increments by 1 each cycle, saturating at 2^CNT_W-1.
  - Held at 0 in IDLE.
- FSM per channel: IDLE, ARM, MEASURE, LOCKED.
  - IDLE: enters ARM when enable=1. cnt=0, lock=0.
  - ARM: the first detected edge loads cnt=1 and moves to MEASURE. No measurement is produced.
  - MEASURE / LOCKED: on a detected edge, period_out[i]<=cnt, period_valid[i]=1 for the following cycle, and cnt<=1.
    - Match is |cnt - exp_period[i]| <= TOL, computed unsigned with a CNT_W+1 bit difference.
    - On a match, match_cnt increments, saturating at LOCK_CNT. The channel goes to LOCKED when match_cnt reaches LOCK_CNT, and lock is set the same cycle period_valid rises.
    - On a mismatch, err_period[i]<=1, match_cnt<=0, lock<=0, and the channel goes to MEASURE.
  - Stuck: in ARM, MEASURE or LOCKED, if cnt==TIMEOUT with no edge that cycle, then err_stuck[i]<=1, lock<=0, match_cnt<=0, and the channel goes to ARM. cnt reloads to 0 and counts again, so stuck is re-flagged each TIMEOUT while the clock is dead.
  - enable=0 from any state: next state IDLE, lock 0. The synchronizers keep running. Sticky flags and period_out are retained.
- Edge at exactly cnt==TIMEOUT: the edge wins. A measurement is taken and compared; no stuck fault is raised.
- clr_err clears all err_period and err_stuck bits. If a set and a clear occur in the same cycle, the set wins.
- A change of exp_period takes effect at the next comparison. Past results are not re-evaluated.
- A reset asserted mid-operation returns everything to the reset values immediately. Measurement restarts from IDLE or ARM after rst deasserts.

Decomposition:
- Package clk_mon_pkg holds:
  - FSM state enum (IDLE, ARM, MEASURE, LOCKED), 2-bit encoding.
  - Default constants CNT_W, LOCK_CNT, TIMEOUT.
  - Helper function abs_diff for the period comparison.
- Sub-module clk_mon_chan holds the synchronizer, edge detect, counter, FSM and flags for one channel. The top instantiates it N_CH times with a generate loop and drives the shared clr_err and enable into every instance.

Test Plan:
1. mon_clk[0] toggles every clk_in cycle (div2), exp_period[0]=2, enable=1 -> period_out[0]=2 on every period_valid pulse. lock[0] rises together with the 4th period_valid pulse (after the 5th detected edge). err flags stay 0.
2. mon_clk[1] is a div4 clock (high 2, low 2), exp_period[1]=2 -> the 1st measurement is 4, err_period[1]=1, lock[1] stays 0. Then reprogram exp_period[1]=4 and pulse clr_err -> err clears and lock[1] rises after 4 matching periods.
3. Hold mon_clk[2] at 0 after lock, TIMEOUT=200 -> err_stuck[2]=1 exactly 200 cycles after the last counter load; lock[2]=0; state ARM. Resume toggling -> lock reacquired after 5 edges.
4. Drop one high phase of a div2 clock on channel 3 (one period measures 4) with TOL=0 -> err_period[3]=1 and lock[3] drops. With TOL=2 in a rerun -> no error, lock held.
5. Assert rst mid-lock on all channels -> all outputs 0 in the same cycle. After release, periods are re-measured, and clr_err coinciding with a new mismatch leaves err_period=1.
